add6_operand_seq: RTL
=====================

# add6_operand_seq

Operand sequencer directly upstream of the 6-bit adder core in the tt_um_6bitaddr design. It synchronises and edge-detects a pin-level strobe, captures two 6-bit operands and a carry-in from the dedicated inputs, and presents them to the adder through a valid/ready handshake. It then captures and holds the 7-bit result for the output pins.

## Interface
- SYNC_STAGES, 2: synchroniser flops on the strobe pin; legal range 2–3.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset; top level drives it as ~rst_n.
- din  in  6  operand value (ui_in[5:0]), sampled only on a strobe event.
- strobe  in  1  asynchronous load pin (ui_in[6]).
- cin_pin  in  1  carry-in pin (ui_in[7]), sampled with operand B.
- op_a  out  6  operand A to the adder.
- op_b  out  6  operand B to the adder.
- op_cin  out  1  carry-in to the adder.
- op_valid  out  1  operands stable and requested.
- op_ready  in  1  adder accepts operands.
- res_in  in  7  adder result {carry, sum[5:0]}.
- res_valid_in  in  1  res_in is valid.
- res_out  out  7  held result.
- res_done  out  1  res_out holds a completed result.
- state_dbg  out  3  current FSM state encoding.

## Operation
- Strobe path: SYNC_STAGES flops, then one edge register. stb_evt is a one-cycle pulse on a synchronised 0→1 transition. A held-high strobe yields exactly one event.
- FSM states (package enum):
  - IDLE: on stb_evt, op_a←din, go to GOT_A.
  - GOT_A: on stb_evt, op_b←din and op_cin←cin_pin, go to ISSUE.
  - ISSUE: op_valid=1. When op_valid&&op_ready, go to WAIT.
  - WAIT: when res_valid_in, res_out←res_in and res_done←1, go to SHOW.
  - SHOW: hold the result. On stb_evt, op_a←din and res_done←0, go to GOT_A.
- stb_evt is ignored in ISSUE and WAIT and is not queued.
- op_a, op_b and op_cin change only on capture events and stay stable while op_valid=1.
- res_in and res_valid_in are ignored outside WAIT.
- res_valid_in in the same cycle the handshake completes is ignored; it is accepted only from the WAIT state.
- Widths: all operands are unsigned 6-bit. The result is 7-bit, with bit 6 the carry. The block performs no arithmetic except in accumulate mode.

## Timing
- Reset values: op_a=0, op_b=0, op_cin=0, op_valid=0, res_out=0, res_done=0, state=IDLE. All synchroniser and edge registers are cleared.
- Strobe latency: the pin rises before clock edge N; stb_evt is high in cycle N+SYNC_STAGES. The capture register updates at the end of that cycle.
- op_valid rises in the cycle after operand B is captured.
- op_valid falls in the cycle after the handshake.
- Combinational adder at the top level (op_ready and res_valid_in tied high): B strobe event at cycle E gives res_done=1 at cycle E+3.
- Reset asserted in any state returns every output to its reset value on the next edge, including mid-handshake with op_valid=1. In-flight results are discarded.

## Configuration
- ADD6_ACCUM_EN defined: in SHOW, stb_evt loads op_a←res_out[5:0], op_b←din and op_cin←cin_pin, then goes directly to ISSUE. This gives a running sum, with overflow visible in res_out[6] per step.
- ADD6_ACCUM_EN undefined: SHOW behaves as described under Operation. No extra logic is instantiated.

## Structure
- Package add6_pkg:
  - OP_W=6 and RES_W=7.
  - The state enum typedef (IDLE, GOT_A, ISSUE, WAIT, SHOW; 3-bit encoding).
  - The synchroniser depth limits.
- Sub-module strobe_sync: parameterised synchroniser plus rising-edge detector producing stb_evt. It uses clk and rst only.

## Test plan
- Reset, then A=5, B=9, cin=0; op_ready and res_valid_in tied high, res_in driven by a model adder → res_out=7'd14, res_done=1, state=SHOW.
- A=63, B=1, cin=0 → res_out=7'h40. With A=63, B=63, cin=1 → res_out=7'h7F.
- Strobe held high for 20 cycles in IDLE → exactly one capture. State stays GOT_A and op_b is unchanged.
- op_ready low for 5 cycles in ISSUE; toggle din and strobe → op_a and op_b stable, op_valid=1 throughout, extra strobes ignored.
- rst pulsed in WAIT while res_valid_in is asserted → next cycle all outputs zero, state=IDLE, res_done=0.
- ADD6_ACCUM_EN: A=10, B=20 → 30; strobe din=40 → res_out=7'd70 (0x46, carry set). Strobe din=1 → op_a=6 → res_out=7'd7.

Source files
------------

// File: rtl/add6_pkg.sv
// Shared widths, synchroniser limits and FSM state type for the 6-bit adder operand sequencer.
package add6_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned RES_W    = 7;
  localparam int unsigned SYNC_MIN = 2;
  localparam int unsigned SYNC_MAX = 3;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StGotA  = 3'd1,
    StIssue = 3'd2,
    StWait  = 3'd3,
    StShow  = 3'd4
  } state_e;

  // Keeps an out-of-range depth from producing a zero-width or oversized chain.
  function automatic int unsigned clamp_sync(input int unsigned n);
    if (n < SYNC_MIN) return SYNC_MIN;
    if (n > SYNC_MAX) return SYNC_MAX;
    return n;
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// Multi-flop synchroniser for the asynchronous strobe pin followed by a rising-edge detector.
module strobe_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_strobe,
  output logic o_evt
);

  logic [STAGES-1:0] r_sync;
  logic              r_edge;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_strobe};
      r_edge <= r_sync[STAGES-1];
    end
  end

  assign o_evt = r_sync[STAGES-1] & ~r_edge;

endmodule

// File: rtl/add6_operand_seq.sv
// Operand sequencer ahead of the 6-bit adder: captures A, then B/cin, issues them, holds the result.
// Optional running-sum mode is enabled by defining ADD6_ACCUM_EN.
module add6_operand_seq
  import add6_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [OP_W-1:0]  i_din,
  input  logic             i_strobe,
  input  logic             i_cin_pin,
  output logic [OP_W-1:0]  o_op_a,
  output logic [OP_W-1:0]  o_op_b,
  output logic             o_op_cin,
  output logic             o_op_valid,
  input  logic             i_op_ready,
  input  logic [RES_W-1:0] i_res_in,
  input  logic             i_res_valid_in,
  output logic [RES_W-1:0] o_res_out,
  output logic             o_res_done,
  output logic [2:0]       o_state_dbg
);

  localparam int unsigned SyncN = clamp_sync(SYNC_STAGES);

  logic w_stb_evt;

  strobe_sync #(
    .STAGES(SyncN)
  ) u_strobe_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_strobe (i_strobe),
    .o_evt    (w_stb_evt)
  );

  state_e            r_state;
  state_e            w_state_nxt;
  logic [OP_W-1:0]   r_op_a;
  logic [OP_W-1:0]   r_op_b;
  logic              r_op_cin;
  logic [RES_W-1:0]  r_res_out;
  logic              r_res_done;

  logic w_load_a;
  logic w_load_b;
  logic w_load_res;
  logic w_clr_done;
`ifdef ADD6_ACCUM_EN
  logic w_load_acc;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_load_res  = 1'b0;
    w_clr_done  = 1'b0;
`ifdef ADD6_ACCUM_EN
    w_load_acc  = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_stb_evt) begin
          w_load_a    = 1'b1;
          w_state_nxt = StGotA;
        end
      end
      StGotA: begin
        if (w_stb_evt) begin
          w_load_b    = 1'b1;
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        if (i_op_ready) w_state_nxt = StWait;
      end
      StWait: begin
        if (i_res_valid_in) begin
          w_load_res  = 1'b1;
          w_state_nxt = StShow;
        end
      end
      StShow: begin
        if (w_stb_evt) begin
`ifdef ADD6_ACCUM_EN
          // Previous sum becomes operand A; the strobed value is the next addend.
          w_load_acc  = 1'b1;
          w_state_nxt = StIssue;
`else
          w_load_a    = 1'b1;
          w_clr_done  = 1'b1;
          w_state_nxt = StGotA;
`endif
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_cin   <= 1'b0;
      r_res_out  <= '0;
      r_res_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_a) r_op_a <= i_din;
      if (w_load_b) begin
        r_op_b   <= i_din;
        r_op_cin <= i_cin_pin;
      end
`ifdef ADD6_ACCUM_EN
      if (w_load_acc) begin
        r_op_a     <= r_res_out[OP_W-1:0];
        r_op_b     <= i_din;
        r_op_cin   <= i_cin_pin;
        r_res_done <= 1'b0;
      end
`endif
      if (w_load_res) begin
        r_res_out  <= i_res_in;
        r_res_done <= 1'b1;
      end else if (w_clr_done) begin
        r_res_done <= 1'b0;
      end
    end
  end

  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_op_cin    = r_op_cin;
  assign o_op_valid  = (r_state == StIssue);
  assign o_res_out   = r_res_out;
  assign o_res_done  = r_res_done;
  assign o_state_dbg = r_state;

endmodule
